// File: rtl/avg_pkg.sv
// Shared definitions for the avg_fast sample source: default sample width and
// the streaming FSM state encoding.
package avg_pkg;

    localparam int AVG_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        STARVE = 2'd2
    } avg_src_state_t;

endpackage

// File: rtl/avg_src_fifo.sv
// Synchronous FIFO feeding the sample source; head is read combinationally,
// full/empty/count are registered and reflect the previous edge.
module avg_src_fifo
    import avg_pkg::*;
#(
    parameter int DW    = AVG_DW,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rs,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic          full_r;
    logic          empty_r;
    logic          wr_acc_s;
    logic          rd_acc_s;

    // A pop needs an entry present before the edge, so a write into an
    // empty FIFO cannot be read back in the same cycle.
    assign wr_acc_s = wr_en & ~full_r;
    assign rd_acc_s = rd_en & ~empty_r;

    // Occupancy after this edge's accepted write/pop.
    always_comb begin
        count_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_s = count_r + CW'(1);
            2'b01:   count_s = count_r - CW'(1);
            default: count_s = count_r;
        endcase
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_s;
            full_r  <= (count_s == DEPTH_C);
            empty_r <= (count_s == {CW{1'b0}});
        end
    end

    // Storage array; contents are don't-care once pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/avg_sample_src.sv
// Paced sample source for the avg_fast averager: FIFO-buffered samples each
// held HOLD clocks. Define AVG_SRC_HOLD_LAST_EN to keep the last sample valid while starved.
module avg_sample_src
    import avg_pkg::*;
#(
    parameter int DW    = AVG_DW,
    parameter int DEPTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     rs,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     start,
    input  logic                     stop,
    output logic [DW-1:0]            num_out,
    output logic                     num_vld,
    output logic                     num_stb,
    output logic                     busy
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD - 1);

    avg_src_state_t state_r;
    avg_src_state_t state_s;
    logic [HW-1:0]  hold_cnt_r;
    logic [HW-1:0]  hold_cnt_s;
    logic           stop_lat_r;
    logic           stop_lat_s;
    logic           stop_eff_s;
    logic           pop_s;
    logic           empty_s;
    logic [DW-1:0]  head_s;
    logic [DW-1:0]  num_out_r;
    logic [DW-1:0]  num_out_s;
    logic           num_vld_r;
    logic           num_vld_s;
    logic           num_stb_r;
    logic           num_stb_s;
    logic           busy_r;
    logic           busy_s;

    avg_src_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rs      (rs),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .full    (full),
        .empty   (empty_s),
        .count   (count)
    );

    // A stop arriving on the final hold clock still ends the stream there.
    assign stop_eff_s = stop_lat_r | stop;

    // State register plus registered outputs.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state_r    <= IDLE;
            hold_cnt_r <= {HW{1'b0}};
            stop_lat_r <= 1'b0;
            num_out_r  <= {DW{1'b0}};
            num_vld_r  <= 1'b0;
            num_stb_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            stop_lat_r <= stop_lat_s;
            num_out_r  <= num_out_s;
            num_vld_r  <= num_vld_s;
            num_stb_r  <= num_stb_s;
            busy_r     <= busy_s;
        end
    end

    // Next-state, hold counter, stop latch and pop decision.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        stop_lat_s = stop_lat_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                stop_lat_s = 1'b0;
                if (start && !empty_s) begin
                    pop_s      = 1'b1;
                    hold_cnt_s = HOLD_LD;
                    state_s    = STREAM;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (hold_cnt_r != {HW{1'b0}}) begin
                    hold_cnt_s = hold_cnt_r - HW'(1);
                    stop_lat_s = stop_eff_s;
                end else if (stop_eff_s) begin
                    stop_lat_s = 1'b0;
                    state_s    = IDLE;
                end else if (!empty_s) begin
                    pop_s      = 1'b1;
                    hold_cnt_s = HOLD_LD;
                end else begin
                    state_s = STARVE;
                end
            end
            STARVE: begin
                if (stop_eff_s) begin
                    stop_lat_s = 1'b0;
                    state_s    = IDLE;
                end else if (!empty_s) begin
                    pop_s      = 1'b1;
                    hold_cnt_s = HOLD_LD;
                    state_s    = STREAM;
                end else begin
                    state_s = STARVE;
                end
            end
            default: begin
                stop_lat_s = 1'b0;
                state_s    = IDLE;
            end
        endcase
    end

    // Output values to be registered on this edge.
    always_comb begin
        num_out_s = num_out_r;
        num_vld_s = 1'b0;
        num_stb_s = 1'b0;
        if (pop_s) begin
            num_out_s = head_s;
            num_vld_s = 1'b1;
            num_stb_s = 1'b1;
        end else begin
            case (state_s)
                STREAM: num_vld_s = 1'b1;
                STARVE: begin
`ifdef AVG_SRC_HOLD_LAST_EN
                    num_vld_s = 1'b1;
`else
                    num_out_s = {DW{1'b0}};
                    num_vld_s = 1'b0;
`endif
                end
                default: num_vld_s = 1'b0;
            endcase
        end
        busy_s = (state_s != IDLE);
    end

    assign num_out = num_out_r;
    assign num_vld = num_vld_r;
    assign num_stb = num_stb_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_avg_sample_src.sv
// Self-checking bench for avg_sample_src: table-driven FIFO fill plus
// hand-written stream/stop/starve/reset sequences against a sample scoreboard.
module tb_avg_sample_src;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int HOLD  = 2;

    logic          clk = 1'b0;
    logic          rs;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic [3:0]    count;
    logic          start;
    logic          stop;
    logic [DW-1:0] num_out;
    logic          num_vld;
    logic          num_stb;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] sb [$];

    typedef struct {
        logic [DW-1:0] data;
        logic          acc;
        logic [3:0]    exp_count;
        logic          exp_full;
    } vec_t;
    vec_t vt [9];

    avg_sample_src #(.DW(DW), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk     (clk),
        .rs      (rs),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .count   (count),
        .start   (start),
        .stop    (stop),
        .num_out (num_out),
        .num_vld (num_vld),
        .num_stb (num_stb),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic write1(input logic [DW-1:0] d, input logic accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) sb.push_back(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic expect_samples(input int n);
        logic [DW-1:0] e;
        for (int k = 0; k < n; k++) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
                e = '0;
            end else begin
                e = sb.pop_front();
            end
            for (int h = 0; h < HOLD; h++) begin
                chk("num_out", num_out, e);
                chk("num_stb", num_stb, (h == 0));
                chk("num_vld", num_vld, 1);
                chk("busy", busy, 1);
                step();
            end
        end
    endtask

    task automatic chk_starve(input logic [DW-1:0] last);
`ifdef AVG_SRC_HOLD_LAST_EN
        chk("starve_out", num_out, last);
        chk("starve_vld", num_vld, 1);
`else
        chk("starve_out", num_out, 0);
        chk("starve_vld", num_vld, 0);
`endif
        chk("starve_stb", num_stb, 0);
        chk("starve_busy", busy, 1);
    endtask

    task automatic go_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_vld", num_vld, 0);
    endtask

    initial begin
        vt[0] = '{8'd200, 1'b1, 4'd1, 1'b0};
        vt[1] = '{8'd100, 1'b1, 4'd2, 1'b0};
        vt[2] = '{8'd200, 1'b1, 4'd3, 1'b0};
        vt[3] = '{8'd255, 1'b1, 4'd4, 1'b0};
        vt[4] = '{8'd91,  1'b1, 4'd5, 1'b0};
        vt[5] = '{8'd25,  1'b1, 4'd6, 1'b0};
        vt[6] = '{8'd100, 1'b1, 4'd7, 1'b0};
        vt[7] = '{8'd25,  1'b1, 4'd8, 1'b1};
        vt[8] = '{8'd77,  1'b0, 4'd8, 1'b1};

        rs = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; stop = 1'b0;
        step();
        step();
        chk("rst_num_out", num_out, 0);
        chk("rst_vld", num_vld, 0);
        chk("rst_stb", num_stb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        rs = 1'b0;
        step();

        // Fill past capacity without start; the ninth write is dropped.
        for (int i = 0; i < 9; i++) begin
            write1(vt[i].data, vt[i].acc);
            chk("fill_count", count, vt[i].exp_count);
            chk("fill_full", full, vt[i].exp_full);
            chk("fill_busy", busy, 0);
        end

        // Start while writing into a full FIFO: write rejected, count 8 -> 7.
        start = 1'b1; wr_en = 1'b1; wr_data = 8'd99;
        step();
        start = 1'b0; wr_en = 1'b0;
        chk("start_count", count, 7);
        chk("start_full", full, 0);
        expect_samples(8);
        chk_starve(8'd25);
        chk("drained_count", count, 0);
        go_idle();

        // Stop on first clock of sample 100 with 3 queued.
        write1(8'd100, 1'b1);
        write1(8'd7, 1'b1);
        write1(8'd8, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("stop_first", num_out, sb.pop_front());
        chk("stop_stb", num_stb, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_hold", num_out, 100);
        chk("stop_hold_vld", num_vld, 1);
        chk("stop_hold_busy", busy, 1);
        step();
        chk("stop_idle_busy", busy, 0);
        chk("stop_idle_vld", num_vld, 0);
        chk("stop_idle_count", count, 2);
        step();
        chk("stop_stays_idle", busy, 0);

        // Write coinciding with a pop at count 4 leaves count at 4.
        write1(8'd9, 1'b1);
        write1(8'd10, 1'b1);
        write1(8'd11, 1'b1);
        chk("sim_pre_count", count, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sim_s7", num_out, sb.pop_front());
        chk("sim_count4", count, 4);
        step();
        wr_en = 1'b1; wr_data = 8'd12; sb.push_back(8'd12);
        step();
        wr_en = 1'b0;
        chk("sim_count_same", count, 4);
        chk("sim_s8", num_out, sb.pop_front());
        chk("sim_s8_stb", num_stb, 1);
        step();
        step();
        expect_samples(4);
        chk_starve(8'd12);
        go_idle();

        // Starve then refill: 24 written 5 clocks after the last pop.
        write1(8'd30, 1'b1);
        write1(8'd25, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        expect_samples(2);
        chk_starve(8'd25);
        step();
        chk_starve(8'd25);
        step();
        chk_starve(8'd25);
        wr_en = 1'b1; wr_data = 8'd24; sb.push_back(8'd24);
        step();
        wr_en = 1'b0;
        chk_starve(8'd25);
        chk("refill_count", count, 1);
        step();
        expect_samples(1);
        chk_starve(8'd24);
        go_idle();

        // Asynchronous reset mid-stream with 5 entries queued.
        for (int i = 0; i < 5; i++) write1(DW'(i + 1), 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #2;
        rs = 1'b1;
        #1;
        chk("arst_num_out", num_out, 0);
        chk("arst_vld", num_vld, 0);
        chk("arst_stb", num_stb, 0);
        chk("arst_busy", busy, 0);
        chk("arst_count", count, 0);
        chk("arst_full", full, 0);
        #1;
        rs = 1'b0;
        sb.delete();
        step();
        chk("post_rst_count", count, 0);
        chk("post_rst_busy", busy, 0);
        write1(8'd50, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        expect_samples(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
